// File: rtl/alu_issue_controller.sv
// Command FIFO plus issue FSM that drives the 8-bit ALU, samples its result/flags and
// returns them on a valid/ready response port. Optional macro: ALU_ISSUE_CHAIN_EN.
module alu_issue_controller #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       cmd_valid_in,
    output logic       cmd_ready_out,
    input  logic [7:0] cmd_opcode_in,
    input  logic [7:0] cmd_operand1_in,
    input  logic [7:0] cmd_operand2_in,
    input  logic       cmd_chain_in,
    output logic       alu_enable_out,
    output logic [7:0] alu_opcode_out,
    output logic [7:0] alu_input1_out,
    output logic [7:0] alu_input2_out,
    input  logic [7:0] alu_output_in,
    input  logic [4:0] alu_flags_in,
    output logic       rsp_valid_out,
    input  logic       rsp_ready_in,
    output logic [7:0] rsp_result_out,
    output logic [4:0] rsp_flags_out,
    output logic       rsp_error_out,
    output logic       busy_out
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FLAG_W = 5;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);

    localparam logic [DATA_W-1:0] OP_ADD  = 8'h00;
    localparam logic [DATA_W-1:0] OP_SUB  = 8'h01;
    localparam logic [DATA_W-1:0] OP_EQ   = 8'h03;
    localparam logic [DATA_W-1:0] OP_GT   = 8'h04;
    localparam logic [DATA_W-1:0] OP_ADDI = 8'h09;
    localparam logic [DATA_W-1:0] OP_SUBI = 8'h0A;

    typedef struct packed {
        logic [DATA_W-1:0] opcode;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
`ifdef ALU_ISSUE_CHAIN_EN
        logic              chain;
`endif
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    function automatic logic is_legal(input logic [DATA_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_ADDI, OP_SUBI: is_legal = 1'b1;
            default:                                        is_legal = 1'b0;
        endcase
    endfunction

    // ---------------------------------------------------------------- command FIFO
    cmd_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cmd_ready_q;
    logic              push, pop;
    logic              fifo_empty;
    cmd_t              push_cmd;
    cmd_t              head;

    assign push       = cmd_valid_in & cmd_ready_q;
    assign fifo_empty = (count_q == CNT_W'(0));
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        push_cmd        = '0;
        push_cmd.opcode = cmd_opcode_in;
        push_cmd.op1    = cmd_operand1_in;
        push_cmd.op2    = cmd_operand2_in;
`ifdef ALU_ISSUE_CHAIN_EN
        push_cmd.chain  = cmd_chain_in;
`endif
    end

`ifndef ALU_ISSUE_CHAIN_EN
    logic unused_chain;
    assign unused_chain = cmd_chain_in;
`endif

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_cmd;
        end
    end

    // ---------------------------------------------------------------- issue FSM
    state_t             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               legal_q, legal_d;
    logic               alu_en_q, alu_en_d;
    logic [DATA_W-1:0]  alu_opc_q, alu_opc_d;
    logic [DATA_W-1:0]  alu_in1_q, alu_in1_d;
    logic [DATA_W-1:0]  alu_in2_q, alu_in2_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0]  rsp_flags_q, rsp_flags_d;
    logic               rsp_error_q, rsp_error_d;
    logic               busy_q, busy_d;
    logic               cmd_ready_d;
    logic [DATA_W-1:0]  head_op1;

`ifdef ALU_ISSUE_CHAIN_EN
    logic [DATA_W-1:0]  chain_q, chain_d;
    // Operand 1 is resolved here, at the moment the command enters ISSUE
    assign head_op1 = head.chain ? chain_q : head.op1;
`else
    assign head_op1 = head.op1;
`endif

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        legal_d      = legal_q;
        alu_en_d     = alu_en_q;
        alu_opc_d    = alu_opc_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_error_d  = rsp_error_q;
        pop          = 1'b0;
`ifdef ALU_ISSUE_CHAIN_EN
        chain_d      = chain_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    // Entry from IDLE holds one extra cycle so acceptance-to-response
                    // latency is 2+SETTLE_CYCLES while back-to-back stays SETTLE_CYCLES+1
                    pop       = 1'b1;
                    alu_opc_d = head.opcode;
                    alu_in1_d = head_op1;
                    alu_in2_d = head.op2;
                    legal_d   = is_legal(head.opcode);
                    alu_en_d  = is_legal(head.opcode);
                    settle_d  = SET_W'(SETTLE_CYCLES);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (settle_q != SET_W'(0)) begin
                    settle_d = settle_q - SET_W'(1);
                end else begin
                    alu_en_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                    if (legal_q) begin
                        rsp_result_d = alu_output_in;
                        rsp_flags_d  = alu_flags_in;
                        rsp_error_d  = 1'b0;
`ifdef ALU_ISSUE_CHAIN_EN
                        chain_d      = alu_output_in;
`endif
                    end else begin
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        rsp_error_d  = 1'b1;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        alu_opc_d = head.opcode;
                        alu_in1_d = head_op1;
                        alu_in2_d = head.op2;
                        legal_d   = is_legal(head.opcode);
                        alu_en_d  = is_legal(head.opcode);
                        settle_d  = SET_W'(SETTLE_CYCLES - 1);
                        state_d   = S_ISSUE;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                alu_en_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    assign busy_d      = (count_d != CNT_W'(0)) || (state_d != S_IDLE);

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= S_IDLE;
            settle_q     <= '0;
            legal_q      <= 1'b0;
            alu_en_q     <= 1'b0;
            alu_opc_q    <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_error_q  <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
`ifdef ALU_ISSUE_CHAIN_EN
            chain_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            legal_q      <= legal_d;
            alu_en_q     <= alu_en_d;
            alu_opc_q    <= alu_opc_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_error_q  <= rsp_error_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
            count_q      <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
`ifdef ALU_ISSUE_CHAIN_EN
            chain_q      <= chain_d;
`endif
        end
    end

    assign cmd_ready_out  = cmd_ready_q;
    assign alu_enable_out = alu_en_q;
    assign alu_opcode_out = alu_opc_q;
    assign alu_input1_out = alu_in1_q;
    assign alu_input2_out = alu_in2_q;
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_result_out = rsp_result_q;
    assign rsp_flags_out  = rsp_flags_q;
    assign rsp_error_out  = rsp_error_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_alu_issue_controller.sv
// Directed self-checking bench for alu_issue_controller with a small behavioural ALU.
module tb_alu_issue_controller;

    logic       clock_in = 1'b0;
    logic       reset_in = 1'b0;
    logic       cmd_valid_in = 1'b0;
    logic       cmd_ready_out;
    logic [7:0] cmd_opcode_in = '0;
    logic [7:0] cmd_operand1_in = '0;
    logic [7:0] cmd_operand2_in = '0;
    logic       cmd_chain_in = 1'b0;
    logic       alu_enable_out;
    logic [7:0] alu_opcode_out;
    logic [7:0] alu_input1_out;
    logic [7:0] alu_input2_out;
    logic [7:0] alu_output_in;
    logic [4:0] alu_flags_in;
    logic       rsp_valid_out;
    logic       rsp_ready_in = 1'b0;
    logic [7:0] rsp_result_out;
    logic [4:0] rsp_flags_out;
    logic       rsp_error_out;
    logic       busy_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic       watch_en = 1'b0;
    logic       en_seen  = 1'b0;

    alu_issue_controller #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .cmd_valid_in    (cmd_valid_in),
        .cmd_ready_out   (cmd_ready_out),
        .cmd_opcode_in   (cmd_opcode_in),
        .cmd_operand1_in (cmd_operand1_in),
        .cmd_operand2_in (cmd_operand2_in),
        .cmd_chain_in    (cmd_chain_in),
        .alu_enable_out  (alu_enable_out),
        .alu_opcode_out  (alu_opcode_out),
        .alu_input1_out  (alu_input1_out),
        .alu_input2_out  (alu_input2_out),
        .alu_output_in   (alu_output_in),
        .alu_flags_in    (alu_flags_in),
        .rsp_valid_out   (rsp_valid_out),
        .rsp_ready_in    (rsp_ready_in),
        .rsp_result_out  (rsp_result_out),
        .rsp_flags_out   (rsp_flags_out),
        .rsp_error_out   (rsp_error_out),
        .busy_out        (busy_out)
    );

    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;
    always @(posedge clock_in) if (watch_en && alu_enable_out) en_seen <= 1'b1;

    // Behavioural ALU; EQ/GT leave V/C/P at stale values {V=1,C=0,P=1}
    logic [8:0] m_sum;
    logic [7:0] m_r;
    always_comb begin
        m_sum = '0;
        m_r   = '0;
        alu_output_in = '0;
        alu_flags_in  = '0;
        case (alu_opcode_out)
            8'h00, 8'h09: begin
                m_sum = {1'b0, alu_input1_out} + {1'b0, alu_input2_out};
                m_r   = m_sum[7:0];
                alu_output_in = m_r;
                alu_flags_in  = {(alu_input1_out[7] == alu_input2_out[7]) && (m_r[7] != alu_input1_out[7]),
                                 m_sum[8], m_r == 8'h00, m_r[7], ^m_r};
            end
            8'h01, 8'h0A: begin
                m_sum = {1'b0, alu_input1_out} - {1'b0, alu_input2_out};
                m_r   = m_sum[7:0];
                alu_output_in = m_r;
                alu_flags_in  = {(alu_input1_out[7] != alu_input2_out[7]) && (m_r[7] != alu_input1_out[7]),
                                 m_sum[8], m_r == 8'h00, m_r[7], ^m_r};
            end
            8'h03: begin
                m_r = (alu_input1_out == alu_input2_out) ? 8'h01 : 8'h00;
                alu_output_in = m_r;
                alu_flags_in  = {1'b1, 1'b0, m_r == 8'h00, m_r[7], 1'b1};
            end
            8'h04: begin
                m_r = (alu_input1_out > alu_input2_out) ? 8'h01 : 8'h00;
                alu_output_in = m_r;
                alu_flags_in  = {1'b1, 1'b0, m_r == 8'h00, m_r[7], 1'b1};
            end
            default: begin
                alu_output_in = 8'hAA;
                alu_flags_in  = 5'h1F;
            end
        endcase
    end

    logic [7:0] res;
    logic [4:0] fl;
    logic       er;
    logic       ok;

    // Offer one command (called at negedge); returns at a negedge after acceptance
    task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic ch, output logic acc_ok);
        logic acc;
        acc_ok = 1'b0;
        cmd_opcode_in = op; cmd_operand1_in = a; cmd_operand2_in = b; cmd_chain_in = ch;
        cmd_valid_in = 1'b1;
        for (int i = 0; i < 20 && !acc_ok; i++) begin
            acc = cmd_ready_out;
            @(posedge clock_in); @(negedge clock_in);
            if (acc) acc_ok = 1'b1;
        end
        cmd_valid_in = 1'b0;
        cmd_chain_in = 1'b0;
    endtask

    task automatic recv_rsp(output logic [7:0] r, output logic [4:0] f, output logic e,
                            output logic got);
        got = 1'b0; r = '0; f = '0; e = 1'b0;
        rsp_ready_in = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (rsp_valid_out) begin
                r = rsp_result_out; f = rsp_flags_out; e = rsp_error_out; got = 1'b1;
            end
            @(posedge clock_in); @(negedge clock_in);
        end
        rsp_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b0;
        #12;
        checks++;
        if ({cmd_ready_out, rsp_valid_out, alu_enable_out, busy_out, rsp_error_out,
             rsp_result_out, rsp_flags_out, alu_opcode_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b en=%b busy=%b err=%b res=%h fl=%h opc=%h exp all zero",
                     cmd_ready_out, rsp_valid_out, alu_enable_out, busy_out, rsp_error_out,
                     rsp_result_out, rsp_flags_out, alu_opcode_out);
        end
        @(negedge clock_in); reset_in = 1'b1;
        @(negedge clock_in);
        checks++;
        if (cmd_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%b busy=%b exp ready=1 busy=0", cmd_ready_out, busy_out);
        end
    endtask

    task automatic test_latency();
        cmd_opcode_in = 8'h00; cmd_operand1_in = 8'h7F; cmd_operand2_in = 8'h01; cmd_valid_in = 1'b1;
        @(posedge clock_in);            // edge N
        @(negedge clock_in); cmd_valid_in = 1'b0;
        checks++;
        if (rsp_valid_out !== 1'b0 || busy_out !== 1'b1) begin
            failures++; $display("FAIL lat_n got valid=%b busy=%b exp valid=0 busy=1", rsp_valid_out, busy_out);
        end
        @(negedge clock_in);            // after N+1
        checks++;
        if ({alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out} !== {1'b1, 8'h00, 8'h7F, 8'h01}
            || rsp_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL lat_issue got en=%b opc=%h a=%h b=%h valid=%b exp en=1 opc=00 a=7f b=01 valid=0",
                     alu_enable_out, alu_opcode_out, alu_input1_out, alu_input2_out, rsp_valid_out);
        end
        @(negedge clock_in);            // after N+2
        checks++;
        if (rsp_valid_out !== 1'b0) begin
            failures++; $display("FAIL lat_n2 got valid=%b exp 0", rsp_valid_out);
        end
        @(negedge clock_in);            // after N+3
        checks++;
        if (rsp_valid_out !== 1'b1 || rsp_result_out !== 8'h80 || rsp_flags_out !== 5'b10011
            || rsp_error_out !== 1'b0 || alu_enable_out !== 1'b0) begin
            failures++;
            $display("FAIL lat_rsp got valid=%b res=%h fl=%b err=%b en=%b exp valid=1 res=80 fl=10011 err=0 en=0",
                     rsp_valid_out, rsp_result_out, rsp_flags_out, rsp_error_out, alu_enable_out);
        end
        @(negedge clock_in);
        checks++;
        if (rsp_valid_out !== 1'b1 || rsp_result_out !== 8'h80 || alu_input1_out !== 8'h7F) begin
            failures++;
            $display("FAIL lat_hold got valid=%b res=%h a=%h exp valid=1 res=80 a=7f",
                     rsp_valid_out, rsp_result_out, alu_input1_out);
        end
        recv_rsp(res, fl, er, ok);
        @(negedge clock_in);
        checks++;
        if (rsp_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++; $display("FAIL lat_drain got valid=%b busy=%b exp 0 0", rsp_valid_out, busy_out);
        end
    endtask

    task automatic test_ops();
        logic [7:0] ops [5] = '{8'h01, 8'h03, 8'h04, 8'h09, 8'h0A};
        logic [7:0] as  [5] = '{8'h00, 8'h05, 8'h03, 8'h10, 8'h05};
        logic [7:0] bs  [5] = '{8'h01, 8'h05, 8'h09, 8'h20, 8'h05};
        logic [7:0] ers [5] = '{8'hFF, 8'h01, 8'h00, 8'h30, 8'h00};
        logic [4:0] efs [5] = '{5'b01010, 5'b10001, 5'b10101, 5'b00000, 5'b00100};
        for (int i = 0; i < 5; i++) begin
            send_cmd(ops[i], as[i], bs[i], 1'b0, ok);
            recv_rsp(res, fl, er, ok);
            checks++;
            if (!ok || res !== ers[i] || fl !== efs[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL op_%0d got ok=%b res=%h fl=%b err=%b exp res=%h fl=%b err=0",
                         i, ok, res, fl, er, ers[i], efs[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] ops [2] = '{8'h07, 8'h02};
        en_seen = 1'b0; watch_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_cmd(ops[i], 8'h12, 8'h34, 1'b0, ok);
            recv_rsp(res, fl, er, ok);
            checks++;
            if (!ok || res !== 8'h00 || fl !== 5'b00000 || er !== 1'b1) begin
                failures++;
                $display("FAIL illegal_%h got ok=%b res=%h fl=%b err=%b exp res=00 fl=00000 err=1",
                         ops[i], ok, res, fl, er);
            end
        end
        watch_en = 1'b0;
        checks++;
        if (en_seen !== 1'b0) begin
            failures++; $display("FAIL illegal_enable got enable_seen=%b exp 0", en_seen);
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int got = 0;
        int last = 0;
        logic acc;
        rsp_ready_in = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (idx < 8) begin
                cmd_opcode_in = 8'h00; cmd_operand1_in = 8'(idx); cmd_operand2_in = 8'h10;
                cmd_valid_in = 1'b1;
            end else begin
                cmd_valid_in = 1'b0;
            end
            acc = cmd_ready_out && (idx < 8);
            @(posedge clock_in); @(negedge clock_in);
            if (acc) idx++;
        end
        cmd_valid_in = 1'b0;
        checks++;
        if (idx != 5 || cmd_ready_out !== 1'b0 || rsp_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL bp_accept got accepted=%0d ready=%b valid=%b exp accepted=5 ready=0 valid=1",
                     idx, cmd_ready_out, rsp_valid_out);
        end
        rsp_ready_in = 1'b1;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (rsp_valid_out) begin
                checks++;
                if (rsp_result_out !== 8'(got + 16)) begin
                    failures++;
                    $display("FAIL bp_order_%0d got res=%h exp %h", got, rsp_result_out, 8'(got + 16));
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        failures++; $display("FAIL bp_rate_%0d got gap=%0d exp 2", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            @(posedge clock_in); @(negedge clock_in);
        end
        rsp_ready_in = 1'b0;
        checks++;
        if (got != 5 || busy_out !== 1'b0) begin
            failures++; $display("FAIL bp_count got responses=%0d busy=%b exp 5 0", got, busy_out);
        end
    endtask

    task automatic test_chain();
        logic [7:0] exp2;
`ifdef ALU_ISSUE_CHAIN_EN
        exp2 = 8'h11;
`else
        exp2 = 8'h5F;
`endif
        send_cmd(8'h00, 8'h03, 8'h04, 1'b0, ok);
        recv_rsp(res, fl, er, ok);
        checks++;
        if (!ok || res !== 8'h07) begin
            failures++; $display("FAIL chain_first got ok=%b res=%h exp 07", ok, res);
        end
        send_cmd(8'h00, 8'h55, 8'h0A, 1'b1, ok);
        recv_rsp(res, fl, er, ok);
        checks++;
        if (!ok || res !== exp2) begin
            failures++; $display("FAIL chain_second got ok=%b res=%h exp %h", ok, res, exp2);
        end
        send_cmd(8'h00, 8'h01, 8'h01, 1'b0, ok);
        recv_rsp(res, fl, er, ok);
        checks++;
        if (!ok || res !== 8'h02) begin
            failures++; $display("FAIL chain_off got ok=%b res=%h exp 02", ok, res);
        end
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        logic seen = 1'b0;
        rsp_ready_in = 1'b0;
        send_cmd(8'h00, 8'h01, 8'h02, 1'b0, ok);
        send_cmd(8'h00, 8'h03, 8'h04, 1'b0, ok);
        send_cmd(8'h00, 8'h05, 8'h06, 1'b0, ok);
        for (int c = 0; c < 10 && !seen; c++) begin
            if (alu_enable_out) seen = 1'b1;
            else begin @(posedge clock_in); @(negedge clock_in); end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL rmid_issue got enable=0 exp 1 within budget");
        end
        #2 reset_in = 1'b0;
        #1;
        checks++;
        if (alu_enable_out !== 1'b0 || rsp_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL rmid_abort got en=%b valid=%b busy=%b exp 0 0 0", alu_enable_out, rsp_valid_out, busy_out);
        end
        @(negedge clock_in); reset_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock_in);
            if (rsp_valid_out || busy_out || alu_enable_out) bad = 1'b1;
        end
        checks++;
        if (bad || cmd_ready_out !== 1'b1) begin
            failures++; $display("FAIL rmid_after got activity=%b ready=%b exp 0 1", bad, cmd_ready_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_ops();
        test_illegal();
        test_back_to_back();
        test_chain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
